// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX register: registered-field layout, forward selects, ALU encoding.
package id_ex_stage_pkg;
  localparam int XLEN_P = 32;
  localparam int RAW_P  = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;

  typedef enum logic [1:0] {FWD_NONE, FWD_MEM, FWD_WB} fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN_P-1:0] pc;
    logic [XLEN_P-1:0] rs1_data;
    logic [XLEN_P-1:0] rs2_data;
    logic [XLEN_P-1:0] imm;
    logic [RAW_P-1:0]  rs1;
    logic [RAW_P-1:0]  rs2;
    logic [RAW_P-1:0]  rd;
    logic [2:0]        alu_control;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } id_ex_t;

  // Empty EX slot: used for reset, flush and load-use bubbles alike.
  function automatic id_ex_t id_ex_bubble();
    id_ex_t b;
    b             = '0;
    b.alu_control = ALU_ADD;
    return b;
  endfunction
endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// One-operand bypass mux: MEM result beats WB result beats the registered read data.
module operand_forward
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [XLEN-1:0]       reg_data_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [XLEN-1:0]       mem_result_i,
  input  logic                  wb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]       wb_result_i,
  output logic [XLEN-1:0]       data_o
);
  fwd_sel_t sel;

  // x0 is hardwired zero, so a match on index 0 must never bypass.
  always_comb begin
    sel = FWD_NONE;
    if (rs_i != '0) begin
      if (mem_reg_write_i && (mem_rd_i == rs_i))     sel = FWD_MEM;
      else if (wb_reg_write_i && (wb_rd_i == rs_i))  sel = FWD_WB;
    end
  end

  always_comb begin
    unique case (sel)
      FWD_MEM: data_o = mem_result_i;
      FWD_WB:  data_o = wb_result_i;
      default: data_o = reg_data_i;
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection and EX-side operand forwarding.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_P,
  parameter int REG_ADDR_W = RAW_P
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [2:0]            id_alu_control,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_result,
  output logic                  load_use_hazard,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [2:0]            ex_alu_control,
  output logic [XLEN-1:0]       ex_left_operand,
  output logic [XLEN-1:0]       ex_right_operand,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg
);
  id_ex_t          ex_q, ex_d;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            wb_hit_rs1, wb_hit_rs2;

  assign load_use_hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0)
                         & ((id_rs1 == ex_q.rd) | (id_uses_rs2 & (id_rs2 == ex_q.rd)));

  assign wb_hit_rs1 = wb_reg_write & (wb_rd != '0) & (wb_rd == ex_q.rs1);
  assign wb_hit_rs2 = wb_reg_write & (wb_rd != '0) & (wb_rd == ex_q.rs2);

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = id_ex_bubble();
    end else if (stall) begin
      // The WB producer retires while we hold; latch it so it is not lost.
      if (wb_hit_rs1) ex_d.rs1_data = wb_result;
      if (wb_hit_rs2) ex_d.rs2_data = wb_result;
    end else if (load_use_hazard) begin
      ex_d = id_ex_bubble();
    end else begin
      ex_d.valid       = id_valid;
      ex_d.pc          = id_pc;
      ex_d.rs1_data    = id_rs1_data;
      ex_d.rs2_data    = id_rs2_data;
      ex_d.imm         = id_imm;
      ex_d.rs1         = id_rs1;
      ex_d.rs2         = id_rs2;
      ex_d.rd          = id_rd;
      ex_d.alu_control = id_alu_control;
      ex_d.alu_src     = id_alu_src;
      ex_d.reg_write   = id_valid & id_reg_write;
      ex_d.mem_read    = id_valid & id_mem_read;
      ex_d.mem_write   = id_valid & id_mem_write;
      ex_d.mem_to_reg  = id_valid & id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= id_ex_bubble();
    else       ex_q <= ex_d;
  end

  operand_forward #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_i(ex_q.rs1), .reg_data_i(ex_q.rs1_data),
    .mem_reg_write_i(mem_reg_write), .mem_rd_i(mem_rd), .mem_result_i(mem_result),
    .wb_reg_write_i(wb_reg_write), .wb_rd_i(wb_rd), .wb_result_i(wb_result),
    .data_o(fwd_rs1)
  );

  operand_forward #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_i(ex_q.rs2), .reg_data_i(ex_q.rs2_data),
    .mem_reg_write_i(mem_reg_write), .mem_rd_i(mem_rd), .mem_result_i(mem_result),
    .wb_reg_write_i(wb_reg_write), .wb_rd_i(wb_rd), .wb_result_i(wb_result),
    .data_o(fwd_rs2)
  );

  assign ex_valid         = ex_q.valid;
  assign ex_pc            = ex_q.pc;
  assign ex_alu_control   = ex_q.alu_control;
  assign ex_left_operand  = fwd_rs1;
  assign ex_right_operand = ex_q.alu_src ? ex_q.imm : fwd_rs2;
  assign ex_store_data    = fwd_rs2;
  assign ex_rd            = ex_q.rd;
  assign ex_reg_write     = ex_q.reg_write;
  assign ex_mem_read      = ex_q.mem_read;
  assign ex_mem_write     = ex_q.mem_write;
  assign ex_mem_to_reg    = ex_q.mem_to_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations plus a randomized run
// against a behavioural model of the EX slot contents.
module tb_id_ex_stage;
  logic        clk, reset;
  logic        id_valid, id_uses_rs2, id_alu_src;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        stall, flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        load_use_hazard, ex_valid;
  logic [31:0] ex_pc, ex_left_operand, ex_right_operand, ex_store_data;
  logic [2:0]  ex_alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int tests = 0;
  int fails = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .stall(stall), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .load_use_hazard(load_use_hazard), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_alu_control(ex_alu_control), .ex_left_operand(ex_left_operand),
    .ex_right_operand(ex_right_operand), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural picture of the instruction sitting in EX.
  bit          m_valid, m_src, m_rw, m_mr, m_mw, m_m2r;
  logic [31:0] m_pc, m_a, m_b, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [2:0]  m_alu;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_src = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
    m_pc = 0; m_a = 0; m_b = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_alu = 0;
  endtask

  // Newest producer wins; register 0 is never bypassed.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] held);
    if (r == 0) return held;
    if (mem_reg_write && mem_rd == r) return mem_result;
    if (wb_reg_write && wb_rd == r) return wb_result;
    return held;
  endfunction

  function automatic bit exp_hazard();
    return id_valid && m_valid && m_mr && m_rd != 0 &&
           (id_rs1 == m_rd || (id_uses_rs2 && id_rs2 == m_rd));
  endfunction

  task automatic check_all();
    chk("hazard", load_use_hazard, exp_hazard());
    chk("ex_valid", ex_valid, m_valid);
    chk("reg_write", ex_reg_write, m_rw);
    chk("mem_read", ex_mem_read, m_mr);
    chk("mem_write", ex_mem_write, m_mw);
    chk("mem_to_reg", ex_mem_to_reg, m_m2r);
    if (m_valid) begin
      chk("pc", ex_pc, m_pc);
      chk("rd", ex_rd, m_rd);
      chk("alu_control", ex_alu_control, m_alu);
      chk("left", ex_left_operand, fwd(m_rs1, m_a));
      chk("right", ex_right_operand, m_src ? m_imm : fwd(m_rs2, m_b));
      chk("store_data", ex_store_data, fwd(m_rs2, m_b));
    end
  endtask

  task automatic model_edge();
    bit haz;
    haz = exp_hazard();
    if (flush) model_clear();
    else if (stall) begin
      if (wb_reg_write && wb_rd != 0 && wb_rd == m_rs1) m_a = wb_result;
      if (wb_reg_write && wb_rd != 0 && wb_rd == m_rs2) m_b = wb_result;
    end else if (haz) model_clear();
    else begin
      m_valid = id_valid; m_pc = id_pc; m_a = id_rs1_data; m_b = id_rs2_data; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_alu = id_alu_control; m_src = id_alu_src;
      m_rw = id_valid & id_reg_write; m_mr = id_valid & id_mem_read;
      m_mw = id_valid & id_mem_write; m_m2r = id_valid & id_mem_to_reg;
    end
  endtask

  // Called just after a falling edge once inputs are driven; returns at the next falling edge.
  task automatic cycle();
    #1;
    if (reset) model_clear();
    check_all();
    @(posedge clk);
    if (reset) model_clear();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; id_rd = 0; id_alu_control = 0; id_alu_src = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    stall = 0; flush = 0; mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic drive_alu(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                           input logic [31:0] d2, input logic [4:0] rd);
    id_valid = 1; id_pc = 32'h100 + {27'd0, rd}; id_rs1 = rs1; id_rs1_data = d1;
    id_rs2 = rs2; id_rs2_data = d2; id_rd = rd; id_uses_rs2 = 1;
    id_alu_control = 3'b000; id_alu_src = 0; id_reg_write = 1;
    id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
  endtask

  initial begin
    drive_idle();
    model_clear();
    reset = 1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_left", ex_left_operand, 0);
    chk("rst_right", ex_right_operand, 0);
    chk("rst_alu", ex_alu_control, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_reg_write", ex_reg_write, 0);
    @(negedge clk);
    reset = 0;

    // Load then hold under stall, with a WB refresh, then flush during stall.
    drive_alu(5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
    cycle();
    id_valid = 0;
    #1;
    chk("load_left", ex_left_operand, 32'd5);
    chk("load_right", ex_right_operand, 32'd7);
    chk("load_valid", ex_valid, 1);
    stall = 1;
    cycle(); cycle(); cycle();
    #1;
    chk("hold_left", ex_left_operand, 32'd5);
    chk("hold_valid", ex_valid, 1);
    wb_reg_write = 1; wb_rd = 5'd1; wb_result = 32'h99;
    cycle();
    wb_reg_write = 0;
    #1;
    chk("stall_refresh", ex_left_operand, 32'h99);
    chk("stall_right", ex_right_operand, 32'd7);
    flush = 1;
    cycle();
    flush = 0; stall = 0;
    #1;
    chk("flush_valid", ex_valid, 0);
    chk("flush_reg_write", ex_reg_write, 0);

    // MEM forward beats WB forward; WB used once MEM drops.
    drive_alu(5'd3, 32'h11, 5'd2, 32'h22, 5'd6);
    cycle();
    id_valid = 0;
    mem_reg_write = 1; mem_rd = 5'd3; mem_result = 32'hAA;
    wb_reg_write = 1; wb_rd = 5'd3; wb_result = 32'hBB;
    #1;
    chk("mem_over_wb", ex_left_operand, 32'hAA);
    mem_reg_write = 0;
    #1;
    chk("wb_only", ex_left_operand, 32'hBB);
    cycle();
    drive_idle();

    // Register 0 never forwards.
    drive_alu(5'd0, 32'd0, 5'd0, 32'd0, 5'd7);
    cycle();
    id_valid = 0;
    mem_reg_write = 1; mem_rd = 5'd0; mem_result = 32'h55;
    wb_reg_write = 1; wb_rd = 5'd0; wb_result = 32'h66;
    #1;
    chk("x0_left", ex_left_operand, 32'd0);
    chk("x0_store", ex_store_data, 32'd0);
    cycle();
    drive_idle();

    // Load-use: the dependent instruction waits one bubble, then enters EX.
    drive_alu(5'd5, 32'h1, 5'd6, 32'h2, 5'd4);
    id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1; id_imm = 32'h8;
    cycle();
    drive_alu(5'd7, 32'h3, 5'd4, 32'h4, 5'd8);
    #1;
    chk("lu_hazard", load_use_hazard, 1);
    cycle();
    #1;
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_rw", ex_reg_write, 0);
    chk("lu_bubble_mr", ex_mem_read, 0);
    chk("lu_hazard_clear", load_use_hazard, 0);
    cycle();
    id_valid = 0;
    #1;
    chk("lu_loaded_valid", ex_valid, 1);
    chk("lu_loaded_rd", ex_rd, 32'd8);
    cycle();

    // Asynchronous reset between edges clears outputs without a clock.
    drive_alu(5'd2, 32'h1234, 5'd3, 32'h5678, 5'd9);
    cycle();
    id_valid = 0;
    #2 reset = 1;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_left", ex_left_operand, 0);
    chk("arst_pc", ex_pc, 0);
    chk("arst_rw", ex_reg_write, 0);
    model_clear();
    @(negedge clk);
    reset = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      id_valid       = ($urandom_range(0, 3) != 0);
      id_pc          = $urandom;
      id_rs1_data    = $urandom;
      id_rs2_data    = $urandom;
      id_imm         = $urandom;
      id_rs1         = 5'($urandom_range(0, 7));
      id_rs2         = 5'($urandom_range(0, 7));
      id_rd          = 5'($urandom_range(0, 7));
      id_uses_rs2    = 1'($urandom_range(0, 1));
      id_alu_control = 3'($urandom_range(0, 7));
      id_alu_src     = 1'($urandom_range(0, 1));
      id_reg_write   = 1'($urandom_range(0, 1));
      id_mem_read    = ($urandom_range(0, 2) == 0);
      id_mem_write   = ($urandom_range(0, 3) == 0);
      id_mem_to_reg  = 1'($urandom_range(0, 1));
      stall          = ($urandom_range(0, 4) == 0);
      flush          = ($urandom_range(0, 9) == 0);
      mem_reg_write  = 1'($urandom_range(0, 1));
      mem_rd         = 5'($urandom_range(0, 7));
      mem_result     = $urandom;
      wb_reg_write   = 1'($urandom_range(0, 1));
      wb_rd          = 5'($urandom_range(0, 7));
      wb_result      = $urandom;
      reset          = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 0;
    drive_idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
